delay_pipe: RTL and testbench
=============================

# delay_pipe

Flow-controlled counterpart of the fixed delay line. It carries a WIDTH-bit payload through DEPTH register stages under a valid/ready handshake. Stalls propagate back to the producer, and interior bubbles collapse, so no data is dropped or duplicated. It sits between pipeline units that must hold a result for a fixed minimum latency but can be back-pressured, for example multi-cycle ALU results waiting on writeback.

## Interface
- WIDTH, 1, payload width in bits
- DEPTH, 2, number of register stages; 0 means combinational pass-through
- RESET, 0, value loaded into every data stage on reset and flush
- ctrl  input  Control bundle  carries the clock (Clock field) and reset (Reset field); one clock, reset asynchronous active-high
- flush  input  1  synchronous clear of all stages
- in_valid  input  1  producer offers in_data
- in_ready  output  1  pipe accepts this cycle
- in_data  input  WIDTH  payload
- out_valid  output  1  stage DEPTH-1 holds data
- out_ready  input  1  consumer accepts this cycle
- out_data  output  WIDTH  payload of stage DEPTH-1
- count  output  clog2(DEPTH+1)  number of occupied stages

## Operation
- Each stage i (0..DEPTH-1) holds v[i] and d[i]. Stage 0 is fed by the input port; stage DEPTH-1 drives the output port.
- Stage move condition: mv[DEPTH-1] = v[DEPTH-1] && out_ready; mv[i] = v[i] && rdy[i+1].
- Stage ready condition: rdy[i] = !v[i] || mv[i]. rdy[0] is in_ready.
- Transfer into stage i happens when rdy[i] and the upstream side is valid (in_valid for stage 0, v[i-1] otherwise).
  - v[i] and d[i] take the upstream value.
  - Otherwise, if mv[i], v[i] becomes 0 and d[i] holds.
  - Otherwise the stage holds.
- Bubble collapse: an empty stage always accepts, even when downstream is stalled.
- in_valid and in_ready have no combinational dependence on each other. in_ready depends combinationally on out_ready through the rdy chain, which is acceptable for DEPTH ≤ 8.
- flush has priority over everything:
  - On the next edge all v go to 0 and all d go to RESET.
  - in_ready is forced to 0 in a flush cycle.
  - Data offered in that cycle is not accepted.
  - out_valid is still driven from the pre-flush state.
- count is registered, equals the popcount of v, and is updated on the same edge as v.
- DEPTH=0: out_valid=in_valid, out_data=in_data, in_ready=out_ready && !flush, count=0.
- A producer must hold in_data stable while in_valid && !in_ready. The pipe itself never drops out_valid without an out_ready handshake, except on flush or reset.

## Timing
- Reset (async assert) sets all v to 0, all d to RESET, out_valid=0, out_data=RESET, count=0 and in_ready=1 immediately.
- Deassertion is sampled on the clock. The first transfer can occur on the first edge after deassertion.
- Latency: a word accepted on edge k appears with out_valid=1 after edge k+DEPTH-1, i.e. visible in the cycle after edge k+DEPTH-1, provided no stall.
- Throughput: 1 word/cycle while out_ready=1.
- Full is count=DEPTH. In that state in_ready=out_ready, so accept and emit happen in the same cycle with count unchanged.
- Empty is count=0. In that state out_valid=0 and out_ready is ignored.
- Reset mid-stream discards all contents immediately. No partial output is emitted.

## Structure
- Sub-module delay_pipe_stage: one v/d register pair with up_valid, up_data, down_ready, flush in; v, d, rdy out. Instantiate DEPTH of these in a generate loop. Handle the DEPTH=0 case in the generate.
- Put the clog2 width function in the shared Util package.
- Take clock/reset accessors from the shared Control definitions.
- No new typedefs.

## Test plan
- Reset, then stream 1..10 with WIDTH=8, DEPTH=3 and out_ready=1 held → out_valid first high 3 cycles after the first accept; outputs are 1..10 in order, one per cycle; count peaks at 3.
- Fill 3 words (0xA1, 0xA2, 0xA3) with out_ready=0 → count=3 and in_ready=0; a fourth word 0xA4 held on in_data stays unaccepted. Raising out_ready gives 0xA1..0xA4 in order with no gaps.
- Inject a bubble: accept 0x11, idle one cycle, accept 0x22 while out_ready=0 → both stages collapse to adjacent entries, count=2. Releasing out_ready gives 0x11 then 0x22 on consecutive cycles.
- Flush with count=2 and in_valid=1 carrying 0x55 → in_ready=0 that cycle; after the edge count=0, out_valid=0 and out_data=RESET; 0x55 never appears at the output.
- Assert reset asynchronously between edges with 3 words in flight → out_valid and count go to 0 immediately without a clock edge; after release, a new word 0x7E emerges with normal latency.
- DEPTH=0 build → out_data tracks in_data in the same cycle, in_ready mirrors out_ready, and flush forces in_ready=0.

Source files
------------

// File: rtl/delay_pipe_pkg.sv
// Shared helpers for delay_pipe: control-bundle accessors and a width helper.
package delay_pipe_pkg;

  localparam int CTRL_W   = 2;
  localparam int CTRL_CLK = 0;
  localparam int CTRL_RST = 1;

  function automatic logic ctrl_clk(input logic [CTRL_W-1:0] c);
    return c[CTRL_CLK];
  endfunction

  function automatic logic ctrl_rst(input logic [CTRL_W-1:0] c);
    return c[CTRL_RST];
  endfunction

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/delay_pipe_stage.sv
// One valid/data register pair of the flow-controlled delay pipe.
module delay_pipe_stage #(
  parameter int               WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             v,
  output logic [WIDTH-1:0] d,
  output logic             rdy
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             mv;

  assign mv  = v_q && down_ready;
  // An empty stage accepts even when downstream is stalled; flush blocks entry.
  assign rdy = (!v_q || mv) && !flush;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = 1'b0;
      d_d = RESET;
    end else if (rdy && up_valid) begin
      v_d = 1'b1;
      d_d = up_data;
    end else if (mv) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= RESET;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v = v_q;
  assign d = d_q;

endmodule

// File: rtl/delay_pipe.sv
// Flow-controlled delay line: DEPTH valid/ready stages with bubble collapse.
module delay_pipe
  import delay_pipe_pkg::*;
#(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET = '0
) (
  input  logic [CTRL_W-1:0]             ctrl,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [clog2_w(DEPTH+1)-1:0]   count
);

  localparam int CW = clog2_w(DEPTH+1);

  logic          clk, rst;
  logic [CW-1:0] count_q, count_d;

  assign clk = ctrl_clk(ctrl);
  assign rst = ctrl_rst(ctrl);

  generate
    if (DEPTH == 0) begin : g_pass
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign in_ready  = out_ready && !flush;
    end else begin : g_pipe
      logic [DEPTH:0]            vld_pipe;
      logic [DEPTH:0]            rdy;
      logic [DEPTH:0][WIDTH-1:0] dat;

      assign vld_pipe[0] = in_valid;
      assign dat[0]      = in_data;
      assign rdy[DEPTH]  = out_ready;

      for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        delay_pipe_stage #(.WIDTH(WIDTH), .RESET(RESET)) u_stage (
          .clk        (clk),
          .rst        (rst),
          .flush      (flush),
          .up_valid   (vld_pipe[i]),
          .up_data    (dat[i]),
          .down_ready (rdy[i+1]),
          .v          (vld_pipe[i+1]),
          .d          (dat[i+1]),
          .rdy        (rdy[i])
        );
      end

      assign in_ready  = rdy[0];
      assign out_valid = vld_pipe[DEPTH];
      assign out_data  = dat[DEPTH];
    end
  endgenerate

  // Interior moves keep occupancy, so only the end handshakes change it.
  always_comb begin
    count_d = count_q;
    if (flush || DEPTH == 0) count_d = '0;
    else count_d = count_q + CW'(in_valid && in_ready) - CW'(out_valid && out_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: tb/tb_delay_pipe.sv
// Directed scoreboard bench for delay_pipe (DEPTH=3 and DEPTH=0 builds).
module tb_delay_pipe;
  import delay_pipe_pkg::*;

  localparam int         W  = 8;
  localparam int         D  = 3;
  localparam logic [W-1:0] RV = 8'hC3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [CTRL_W-1:0] ctrl;

  always #5 clk = ~clk;
  always_comb begin
    ctrl           = '0;
    ctrl[CTRL_CLK] = clk;
    ctrl[CTRL_RST] = rst;
  end

  logic         flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  logic         z_flush = 1'b0, z_in_valid = 1'b0, z_out_ready = 1'b0;
  logic [W-1:0] z_in_data = '0;
  logic         z_in_ready, z_out_valid;
  logic [W-1:0] z_out_data;
  logic [0:0]   z_count;

  delay_pipe #(.WIDTH(W), .DEPTH(D), .RESET(RV)) dut (
    .ctrl(ctrl), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count)
  );

  delay_pipe #(.WIDTH(W), .DEPTH(0), .RESET(RV)) dut0 (
    .ctrl(ctrl), .flush(z_flush), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .in_data(z_in_data), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_data(z_out_data), .count(z_count)
  );

  int checks = 0, errors = 0, cyc = 0;
  int first_acc, first_emit, last_emit, n_emit, max_cnt;
  bit acc_last;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    first_acc = -1; first_emit = -1; last_emit = -1; n_emit = 0; max_cnt = 0;
  endtask

  // Sample handshakes mid low phase, run the scoreboard, advance one cycle.
  task automatic tick();
    #2;
    acc_last = in_valid && in_ready;
    if (acc_last) begin
      exp_q.push_back(in_data);
      if (first_acc < 0) first_acc = cyc;
    end
    if (out_valid && out_ready) begin
      if (first_emit < 0) first_emit = cyc;
      last_emit = cyc;
      n_emit++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL unexpected_out observed=%0h expected=none", out_data);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
    if (int'(count) > max_cnt) max_cnt = int'(count);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int nxt;
    clr_stats();
    // Async reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, RV);
    @(negedge clk);
    rst = 1'b0;

    // Streaming 1..10 with out_ready held
    out_ready = 1'b1;
    nxt = 1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (nxt <= 10);
      in_data  = W'(nxt);
      tick();
      if (acc_last) nxt++;
    end
    in_valid = 1'b0;
    chk("stream_latency", first_emit - first_acc, 3);
    chk("stream_n_emit", n_emit, 10);
    chk("stream_no_gaps", last_emit - first_emit, 9);
    chk("stream_peak_count", max_cnt, 3);
    chk("stream_q_empty", exp_q.size(), 0);

    // Fill under back-pressure, fourth word held off
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = W'(8'hA1 + k);
      tick();
    end
    in_data = 8'hA4;
    #1;
    chk("full_count", count, 3);
    chk("full_in_ready", in_ready, 0);
    tick();
    #1;
    chk("full_hold_in_ready", in_ready, 0);
    chk("full_hold_count", count, 3);
    clr_stats();
    out_ready = 1'b1;
    #1;
    chk("full_ready_follows", in_ready, 1);
    tick();
    chk("full_accept_emit", acc_last, 1);
    in_valid = 1'b0;
    #1;
    chk("full_count_steady", count, 3);
    for (int c = 0; c < 8; c++) tick();
    chk("fill_n_emit", n_emit, 4);
    chk("fill_no_gaps", last_emit - first_emit, 3);
    chk("fill_q_empty", exp_q.size(), 0);

    // Bubble collapse
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 8'h22; tick();
    in_valid = 1'b0; tick();
    #1;
    chk("bubble_count", count, 2);
    chk("bubble_out_valid", out_valid, 1);
    clr_stats();
    out_ready = 1'b1;
    tick();
    #1;
    chk("bubble_second_valid", out_valid, 1);
    tick();
    chk("bubble_n_emit", n_emit, 2);
    chk("bubble_adjacent", last_emit - first_emit, 1);
    chk("bubble_q_empty", exp_q.size(), 0);

    // Flush with data offered in the same cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h31; tick();
    in_data = 8'h32; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 8'h55; flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_pre_out_valid", out_valid, 1);
    chk("flush_pre_count", count, 2);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_data", out_data, RV);
    clr_stats();
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    chk("flush_no_output", n_emit, 0);

    // Asynchronous reset with three words in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = W'(8'h61 + k);
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_data", out_data, RV);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    clr_stats();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h7E;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("arst_latency", first_emit - first_acc, 3);
    chk("arst_n_emit", n_emit, 1);

    // DEPTH=0 pass-through
    z_in_valid = 1'b1; z_in_data = 8'h3C; z_out_ready = 1'b1;
    #1;
    chk("z_out_data", z_out_data, 8'h3C);
    chk("z_out_valid", z_out_valid, 1);
    chk("z_in_ready", z_in_ready, 1);
    z_in_data = 8'hA5;
    #1;
    chk("z_out_data_track", z_out_data, 8'hA5);
    z_out_ready = 1'b0;
    #1;
    chk("z_in_ready_stall", z_in_ready, 0);
    z_out_ready = 1'b1; z_flush = 1'b1;
    #1;
    chk("z_flush_in_ready", z_in_ready, 0);
    z_flush = 1'b0;
    #1;
    chk("z_in_ready_back", z_in_ready, 1);
    chk("z_count", z_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
